// File: rtl/store_row_mover.sv
// store_row_mover: captures a three-register store config, then moves one
// SRAM C row to DRAM through a 4-entry buffer. Option: STORE_ROW_MOVER_STALL_CNT_EN.
module store_row_mover #(
    parameter int FIFO_WIDTH = 32,
    parameter int SRAM_AW    = 12,
    parameter int LEN_W      = 8,
    parameter logic [FIFO_WIDTH-1:0] CFG_LEN_ADDR  = 'h0000_0010,
    parameter logic [FIFO_WIDTH-1:0] CFG_SRAM_ADDR = 'h0000_0014,
    parameter logic [FIFO_WIDTH-1:0] CFG_DRAM_ADDR = 'h0000_0018
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_req,
    input  logic [FIFO_WIDTH-1:0] cfg_addr,
    input  logic                  cfg_addr_vld,
    input  logic [FIFO_WIDTH-1:0] cfg_data,
    input  logic                  cfg_data_vld,
    output logic                  cfg_ack,
    input  logic                  start,
    output logic                  busy,
    output logic                  sram_rd_en,
    output logic [SRAM_AW-1:0]    sram_rd_addr,
    input  logic [FIFO_WIDTH-1:0] sram_rd_data,
    input  logic                  sram_rd_vld,
    output logic                  dram_wr_req,
    output logic [FIFO_WIDTH-1:0] dram_wr_addr,
    output logic [FIFO_WIDTH-1:0] dram_wr_data,
    input  logic                  dram_wr_ready,
    output logic                  row_done,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0]      len_q;
    logic [SRAM_AW-1:0]    sram_q;
    logic [FIFO_WIDTH-1:0] dram_q;
    logic [2:0]            seen_q;
    logic                  cfg_ack_q;

    logic [LEN_W-1:0]      rd_cnt_q, wr_cnt_q;
    logic [2:0]            out_q, cnt_q;
    logic [1:0]            wp_q, rp_q;
    logic [FIFO_WIDTH-1:0] mem_q [4];

    logic       cfg_wr, go, rd_issue, push, pop, last;
    logic [2:0] hit, seen_nx;
    logic [SRAM_AW-1:0] row_base;

    assign cfg_wr  = cfg_req && cfg_addr_vld && cfg_data_vld && (state_q == IDLE);
    assign hit     = {cfg_addr == CFG_DRAM_ADDR,
                      cfg_addr == CFG_SRAM_ADDR,
                      cfg_addr == CFG_LEN_ADDR} & {3{cfg_wr}};
    assign seen_nx = seen_q | hit;
    assign go      = (state_q == IDLE) && start;

    assign row_base = sram_q * SRAM_AW'(len_q);
    assign rd_issue = (state_q == RUN) && (rd_cnt_q < len_q)
                      && (({1'b0, out_q} + {1'b0, cnt_q}) < 4'd4);
    assign push     = (state_q == RUN) && sram_rd_vld && (out_q != 3'd0);
    assign pop      = dram_wr_req && dram_wr_ready;
    assign last     = pop && (wr_cnt_q == len_q - LEN_W'(1));

    assign cfg_ack      = cfg_ack_q;
    assign busy         = (state_q != IDLE);
    assign row_done     = (state_q == DONE);
    assign sram_rd_en   = rd_issue;
    assign sram_rd_addr = rd_issue ? row_base + SRAM_AW'(rd_cnt_q) : '0;
    assign dram_wr_req  = (state_q == RUN) && (cnt_q != 3'd0);
    assign dram_wr_addr = dram_wr_req ? dram_q + FIFO_WIDTH'(wr_cnt_q) : '0;
    assign dram_wr_data = dram_wr_req ? mem_q[rp_q] : '0;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: zero-length rows skip straight to DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = (len_q != '0) ? RUN : DONE;
            RUN:  if (last)  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Config capture; ack once all three registers have been seen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q     <= '0;
            sram_q    <= '0;
            dram_q    <= '0;
            seen_q    <= '0;
            cfg_ack_q <= 1'b0;
        end else begin
            cfg_ack_q <= 1'b0;
            if (hit[0]) len_q  <= cfg_data[LEN_W-1:0];
            if (hit[1]) sram_q <= cfg_data[SRAM_AW-1:0];
            if (hit[2]) dram_q <= cfg_data;
            if (&seen_nx) begin
                seen_q    <= '0;
                cfg_ack_q <= 1'b1;
            end else begin
                seen_q <= seen_nx;
            end
        end
    end

    // Read/write counters, outstanding reads and buffer bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
        end else if (go) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
        end else if (state_q == RUN) begin
            rd_cnt_q <= rd_cnt_q + LEN_W'(rd_issue);
            wr_cnt_q <= wr_cnt_q + LEN_W'(pop);
            out_q    <= out_q + 3'(rd_issue) - 3'(push);
            cnt_q    <= cnt_q + 3'(push) - 3'(pop);
            wp_q     <= wp_q + 2'(push);
            rp_q     <= rp_q + 2'(pop);
            if (push) mem_q[wp_q] <= sram_rd_data;
        end
    end

`ifdef STORE_ROW_MOVER_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of backpressured DRAM cycles, cleared per row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else if (go)
            stall_q <= '0;
        else if (dram_wr_req && !dram_wr_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_store_row_mover.sv
// tb_store_row_mover: scoreboard bench for store_row_mover.
// SRAM model has read latency 1; DRAM ready is scripted or random.
module tb_store_row_mover;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_req = 1'b0;
    logic [31:0] cfg_addr = '0;
    logic        cfg_addr_vld = 1'b0;
    logic [31:0] cfg_data = '0;
    logic        cfg_data_vld = 1'b0;
    logic        cfg_ack;
    logic        start = 1'b0;
    logic        busy;
    logic        sram_rd_en;
    logic [11:0] sram_rd_addr;
    logic [31:0] sram_rd_data = '0;
    logic        sram_rd_vld = 1'b0;
    logic        dram_wr_req;
    logic [31:0] dram_wr_addr;
    logic [31:0] dram_wr_data;
    logic        dram_wr_ready = 1'b1;
    logic        row_done;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_rd [$];
    logic [63:0] exp_wr [$];

    store_row_mover dut (
        .clk(clk), .rst(rst),
        .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_addr_vld(cfg_addr_vld),
        .cfg_data(cfg_data), .cfg_data_vld(cfg_data_vld), .cfg_ack(cfg_ack),
        .start(start), .busy(busy),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data), .sram_rd_vld(sram_rd_vld),
        .dram_wr_req(dram_wr_req), .dram_wr_addr(dram_wr_addr),
        .dram_wr_data(dram_wr_data), .dram_wr_ready(dram_wr_ready),
        .row_done(row_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [11:0] a);
        return 32'h5A00_0000 + 32'(a) * 32'd977;
    endfunction

    task automatic test_reset();
        logic [96:0] o;
        #1;
        o = {cfg_ack, busy, sram_rd_en, sram_rd_addr, dram_wr_req,
             dram_wr_addr, dram_wr_data, row_done, stall_cnt};
        checks++;
        if (o !== 97'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic cfg3(input logic [31:0] l, input logic [31:0] s,
                        input logic [31:0] d);
        logic [31:0] a [3];
        logic [31:0] v [3];
        a[0] = 32'h10; a[1] = 32'h14; a[2] = 32'h18;
        v[0] = l;      v[1] = s;      v[2] = d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (cfg_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL cfg_ack_early: got %b want 0", cfg_ack);
                end
            end
            cfg_req = 1'b1; cfg_addr_vld = 1'b1; cfg_data_vld = 1'b1;
            cfg_addr = a[i]; cfg_data = v[i];
        end
        @(negedge clk);
        cfg_req = 1'b0; cfg_addr_vld = 1'b0; cfg_data_vld = 1'b0;
        checks++;
        if (cfg_ack !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ack: got %b want 1", cfg_ack);
        end
        @(negedge clk);
        checks++;
        if (cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ack_width: got %b want 0", cfg_ack);
        end
    endtask

    task automatic run_row(input int len, input int sr, input logic [31:0] db,
                           input int stall_n, input bit rnd,
                           input int kill_at, input bit poke);
        int cyc, hs, issued, done_cnt, done_cyc, first_hs, last_hs;
        int stalls_left, stall_seen, max_inf, exp_done;
        bit pend_v, killed;
        logic [31:0] pend_d;
        logic [11:0] ea;
        logic [63:0] ew;
        logic [96:0] o;
        logic [15:0] exp_stall;
        exp_rd.delete();
        exp_wr.delete();
        for (int i = 0; i < len; i++) begin
            ea = 12'(sr * len + i);
            exp_rd.push_back(ea);
            exp_wr.push_back({db + 32'(i), data_of(ea)});
        end
        hs = 0; issued = 0; done_cnt = 0; done_cyc = -1;
        first_hs = -1; last_hs = -1; stalls_left = stall_n;
        stall_seen = 0; max_inf = 0; pend_v = 1'b0; pend_d = '0;
        killed = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: got %b want 1", busy);
        end
        checks++;
        if (sram_rd_en !== (len > 0)) begin
            errors++;
            $display("FAIL first_read: got %b want %b", sram_rd_en, len > 0);
        end
        while (cyc < 200 && (done_cyc < 0 || cyc < done_cyc + 3) && !killed) begin
            if (kill_at > 0 && hs == kill_at) begin
                rst = 1'b0; sram_rd_vld = 1'b0; dram_wr_ready = 1'b1;
                #1;
                o = {cfg_ack, busy, sram_rd_en, sram_rd_addr, dram_wr_req,
                     dram_wr_addr, dram_wr_data, row_done, stall_cnt};
                checks++;
                if (o !== 97'd0) begin
                    errors++;
                    $display("FAIL kill_outputs: got %h want 0", o);
                end
                repeat (3) begin
                    @(negedge clk);
                    if (row_done) done_cnt++;
                end
                rst = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    if (row_done) done_cnt++;
                end
                checks++;
                if (done_cnt != 0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL kill_idle: got done=%0d busy=%b want 0 0",
                             done_cnt, busy);
                end
                killed = 1'b1;
            end else begin
                if (row_done) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (poke && cyc == 3) begin
                    start = 1'b1; cfg_req = 1'b1; cfg_addr_vld = 1'b1;
                    cfg_data_vld = 1'b1; cfg_addr = 32'h10; cfg_data = 32'd9;
                end else begin
                    start = 1'b0; cfg_req = 1'b0; cfg_addr_vld = 1'b0;
                    cfg_data_vld = 1'b0;
                end
                sram_rd_vld = pend_v;
                sram_rd_data = pend_d;
                pend_v = sram_rd_en;
                if (sram_rd_en) begin
                    pend_d = data_of(sram_rd_addr);
                    issued++;
                    checks++;
                    if (exp_rd.size() == 0) begin
                        errors++;
                        $display("FAIL rd_extra: got addr %h want no read",
                                 sram_rd_addr);
                    end else begin
                        ea = exp_rd.pop_front();
                        if (sram_rd_addr !== ea) begin
                            errors++;
                            $display("FAIL rd_addr: got %h want %h",
                                     sram_rd_addr, ea);
                        end
                    end
                end
                if (rnd)
                    dram_wr_ready = ($urandom_range(0, 2) != 0);
                else if (dram_wr_req && stalls_left > 0) begin
                    dram_wr_ready = 1'b0;
                    stalls_left--;
                end else
                    dram_wr_ready = 1'b1;
                if (dram_wr_req && !dram_wr_ready) stall_seen++;
                if (issued - hs > max_inf) max_inf = issued - hs;
                if (dram_wr_req && dram_wr_ready) begin
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                    hs++;
                    checks++;
                    if (exp_wr.size() == 0) begin
                        errors++;
                        $display("FAIL wr_extra: got %h/%h want no write",
                                 dram_wr_addr, dram_wr_data);
                    end else begin
                        ew = exp_wr.pop_front();
                        if ({dram_wr_addr, dram_wr_data} !== ew) begin
                            errors++;
                            $display("FAIL wr_beat: got %h/%h want %h/%h",
                                     dram_wr_addr, dram_wr_data,
                                     ew[63:32], ew[31:0]);
                        end
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; cfg_req = 1'b0; cfg_addr_vld = 1'b0; cfg_data_vld = 1'b0;
        sram_rd_vld = 1'b0; dram_wr_ready = 1'b1;
        if (!killed) begin
            exp_done = (len == 0) ? 1 : last_hs + 1;
`ifdef STORE_ROW_MOVER_STALL_CNT_EN
            exp_stall = 16'(stall_seen);
`else
            exp_stall = 16'd0;
`endif
            checks++;
            if (done_cnt != 1 || done_cyc != exp_done) begin
                errors++;
                $display("FAIL row_done: got count=%0d cyc=%0d want 1 at %0d",
                         done_cnt, done_cyc, exp_done);
            end
            checks++;
            if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
                errors++;
                $display("FAIL row_complete: got rd_left=%0d wr_left=%0d want 0 0",
                         exp_rd.size(), exp_wr.size());
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_fall: got %b want 0", busy);
            end
            checks++;
            if (max_inf > 4) begin
                errors++;
                $display("FAIL inflight: got %0d want <=4", max_inf);
            end
            checks++;
            if (stall_cnt !== exp_stall) begin
                errors++;
                $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
            end
            if (!rnd && stall_n == 0 && len > 0) begin
                checks++;
                if (last_hs - first_hs != len - 1) begin
                    errors++;
                    $display("FAIL throughput: got span %0d want %0d",
                             last_hs - first_hs, len - 1);
                end
            end
        end
    endtask

    task automatic test_config();
        cfg3(32'd4, 32'd2, 32'h1000);
        @(negedge clk);
        cfg_req = 1'b1; cfg_addr_vld = 1'b1; cfg_data_vld = 1'b1;
        cfg_addr = 32'h20; cfg_data = 32'hDEAD;
        @(negedge clk);
        cfg_req = 1'b0; cfg_addr_vld = 1'b0; cfg_data_vld = 1'b0;
        repeat (2) begin
            checks++;
            if (cfg_ack !== 1'b0) begin
                errors++;
                $display("FAIL cfg_unmatched_ack: got %b want 0", cfg_ack);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_nominal();
        run_row(4, 2, 32'h1000, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_row(4, 2, 32'h1000, 6, 1'b0, 0, 1'b0);
    endtask

    task automatic test_zero_len();
        cfg3(32'd0, 32'd5, 32'h2000);
        run_row(0, 5, 32'h2000, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_busy_filter();
        cfg3(32'd4, 32'd2, 32'h1000);
        run_row(4, 2, 32'h1000, 0, 1'b0, 0, 1'b1);
        run_row(4, 2, 32'h1000, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_row();
        run_row(4, 2, 32'h1000, 0, 1'b0, 2, 1'b0);
        cfg3(32'd3, 32'd7, 32'hFFFF_FFFE);
        run_row(3, 7, 32'hFFFF_FFFE, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random_ready();
        cfg3(32'd20, 32'd300, 32'h40);
        run_row(20, 300, 32'h40, 0, 1'b1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_config();
        test_nominal();
        test_backpressure();
        test_zero_len();
        test_busy_filter();
        test_reset_mid_row();
        test_random_ready();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_row_mover.md
# store_row_mover

Downstream consumer of the DFU store sequencer, on the arbiter side. It captures the three-word store configuration (row length, SRAM row index, DRAM base address) written over the arbiter read-request bus. On a start pulse it moves one row of words from SRAM C to DRAM through a 4-entry elastic buffer. When the last DRAM write is accepted it pulses `row_done`, which the sequencer consumes as `ack_sram_c_rd`.

## Interface
- `FIFO_WIDTH`, 32: configuration bus and DRAM address/data width.
- `SRAM_AW`, 12: SRAM word-address width.
- `LEN_W`, 8: row-length width; lengths 0..255.
- `CFG_LEN_ADDR`, 32'h0000_0010: register address of row length.
- `CFG_SRAM_ADDR`, 32'h0000_0014: register address of SRAM row index.
- `CFG_DRAM_ADDR`, 32'h0000_0018: register address of DRAM base.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cfg_req`  in  1  configuration write request.
- `cfg_addr`  in  FIFO_WIDTH  register address; qualified by `cfg_addr_vld`.
- `cfg_addr_vld`  in  1  address valid.
- `cfg_data`  in  FIFO_WIDTH  write data; qualified by `cfg_data_vld`.
- `cfg_data_vld`  in  1  data valid.
- `cfg_ack`  out  1  one-cycle pulse: all three registers captured.
- `start`  in  1  one-cycle start pulse (sequencer read interrupt).
- `busy`  out  1  high from accepted start until `row_done` inclusive.
- `sram_rd_en`  out  1  SRAM read strobe.
- `sram_rd_addr`  out  SRAM_AW  SRAM word address.
- `sram_rd_data`  in  FIFO_WIDTH  SRAM read data.
- `sram_rd_vld`  in  1  read data valid; latency ≥1, in order.
- `dram_wr_req`  out  1  DRAM write valid.
- `dram_wr_addr`  out  FIFO_WIDTH  DRAM word address.
- `dram_wr_data`  out  FIFO_WIDTH  DRAM write data.
- `dram_wr_ready`  in  1  DRAM accepts when `dram_wr_req && dram_wr_ready`.
- `row_done`  out  1  one-cycle pulse: row complete.
- `stall_cnt`  out  16  DRAM backpressure cycle count (see Configuration).

## Operation
**Configuration capture**
- A write occurs when `cfg_req && cfg_addr_vld && cfg_data_vld` in IDLE.
- Address match loads the corresponding register: `len_q` ← `cfg_data[LEN_W-1:0]`; `sram_q`, `dram_q` ← full data. The matching seen-bit is set.
- Unmatched addresses are ignored.
- When all three seen-bits are set, `cfg_ack` pulses the next cycle and the seen-bits clear.
- Rewriting a register before all three are seen overwrites it, with no extra ack.
- Writes while `busy` are ignored entirely.

**States: IDLE → RUN → DONE → IDLE**
- IDLE:
  - `start && len_q != 0` → RUN. Clear `rd_cnt`, `wr_cnt`, buffer.
  - `start && len_q == 0` → DONE.
  - `start` and a config write in the same cycle: the write is applied, and start uses the pre-write register values.
- RUN, read issue:
  - Drive `sram_rd_en` when `rd_cnt < len_q && (outstanding + occupancy) < 4`.
  - `sram_rd_addr` = (`sram_q` × `len_q` + `rd_cnt`) truncated to SRAM_AW.
  - `rd_cnt` increments on each issue.
- RUN, buffering: `sram_rd_vld` pushes `sram_rd_data` into the 4-entry FIFO.
- RUN, DRAM write:
  - `dram_wr_req` = FIFO not empty.
  - `dram_wr_data` = FIFO head.
  - `dram_wr_addr` = `dram_q + wr_cnt`, modulo 2^FIFO_WIDTH.
  - On handshake: pop and increment `wr_cnt`.
  - Handshake with `wr_cnt == len_q-1` → DONE.
- DONE: `row_done` = 1 for exactly one cycle, then → IDLE. Config registers are retained.
- `start` while busy is ignored.
- A `sram_rd_vld` with no outstanding read is dropped. The FIFO never overflows by construction.

## Timing
- Every output resets to 0. Internal state also resets: IDLE, counters 0, seen-bits 0, config registers 0.
- `cfg_ack`: cycle N+1 after the third-register write in cycle N.
- `busy` rises the cycle after `start`.
- First `sram_rd_en` is in the first RUN cycle, i.e. `start` + 1.
- With SRAM latency 1 and `dram_wr_ready` held high, row throughput is 1 word/cycle.
- `row_done` is asserted 1 cycle after the final DRAM handshake. `busy` falls the cycle after `row_done`.
- For `len_q == 0`, `row_done` is asserted at `start` + 1.
- DRAM outputs are registered/held stable while `dram_wr_req && !dram_wr_ready`.
- Reset mid-RUN: immediate return to IDLE. Buffer contents are discarded, and no `row_done` is issued.

## Configuration
- `STORE_ROW_MOVER_STALL_CNT_EN` defined:
  - `stall_cnt` counts cycles with `dram_wr_req && !dram_wr_ready`.
  - Saturates at 16'hFFFF.
  - Clears at each accepted `start`.
  - Holds its value after `row_done`.
- Not defined: `stall_cnt` tied to 0 and no counter logic is synthesized.

## Test plan
- **Config ack:** write len=4, sram=2, dram=0x1000 in 3 consecutive cycles → `cfg_ack` high one cycle after the third write; no ack after an extra write to 0x20.
- **Nominal row:** len=4, sram=2, dram=0x1000, SRAM latency 1, ready=1 → reads at addresses 8,9,10,11; DRAM writes 0x1000..0x1003 with matching data in order; `row_done` one cycle after the last write.
- **Backpressure:** same config with `dram_wr_ready` low for 6 cycles from the first request → at most 4 reads outstanding or buffered; data intact; `stall_cnt` = 6 when macro defined, 0 otherwise.
- **Zero length:** len=0 with start → no SRAM/DRAM activity; `row_done` at start+1.
- **Busy filtering:** config write and second `start` during RUN → both ignored; registers unchanged; single `row_done`.
- **Reset mid-row:** reset asserted after 2 of 4 DRAM writes (len=4) → all outputs 0; IDLE; no `row_done`; a new full config plus start completes normally.
